// File: rtl/rom_to_mem_loader_pkg.sv
// Shared types for the ROM-to-memory loader.
//  state_t   : loader FSM states, also exported on the debug state port.
//  MEM_WRITE / MEM_READ : encoding of the memory port rw strobe.
package rom_to_mem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    REQ   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MEM_WRITE = 1'b1;
  localparam logic MEM_READ  = 1'b0;

endpackage

// File: rtl/rom_to_mem_loader_lane_expand.sv
// Combinational lane width converter.
//  Splits i_data into ROM_DW/LANE_IN lanes of LANE_IN bits and widens each
//  lane to LANE_OUT bits (sign- or zero-extended by SIGN_EXT).
//  Ports:
//   i_data  in   ROM_DW                     packed source lanes, lane 0 in the LSBs
//   o_data  out  ROM_DW/LANE_IN*LANE_OUT     widened lanes, same lane order
module rom_to_mem_loader_lane_expand #(
  parameter int ROM_DW   = 64,
  parameter int LANE_IN  = 8,
  parameter int LANE_OUT = 32,
  parameter int SIGN_EXT = 0
) (
  input  logic [ROM_DW-1:0]                    i_data,
  output logic [ROM_DW/LANE_IN*LANE_OUT-1:0]   o_data
);

  localparam int NUM_LANES = ROM_DW / LANE_IN;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [LANE_IN-1:0] w_lane;
    assign w_lane = i_data[k*LANE_IN +: LANE_IN];
    if (SIGN_EXT != 0) begin : g_sext
      assign o_data[k*LANE_OUT +: LANE_OUT] = LANE_OUT'($signed(w_lane));
    end else begin : g_zext
      assign o_data[k*LANE_OUT +: LANE_OUT] = LANE_OUT'(w_lane);
    end
  end

endmodule

// File: rtl/rom_to_mem_loader.sv
// ROM-to-memory bulk loader.
//  On i_start it streams NUM_WORDS ROM words, widens every lane and writes each
//  widened word to BASE_ADDR + i*ADDR_STEP. In verify mode the same region is
//  read back instead and lane-word mismatches are counted (saturating).
//  Handshake: a request is presented with o_mem_valid_data=1 and its address,
//  data and rw held stable; it completes on the first cycle i_mem_ready_data
//  is high while valid is high. Ready with valid low is ignored.
//  Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_start, i_verify     run start pulse (ignored while busy), mode sampled at start
//   o_rom_addr/i_rom_data ROM port, data valid ROM_LAT cycles after the address
//   o_mem_*/i_mem_*       memory data port (write data, read data, address, rw, valid, ready)
//   o_busy, o_done        run in progress, one-cycle end-of-run pulse
//   o_err_count           verify mismatch count
//   o_state               FSM state (debug)
module rom_to_mem_loader
  import rom_to_mem_loader_pkg::*;
#(
  parameter int                ROM_DW    = 64,
  parameter int                ROM_AW    = 16,
  parameter int                NUM_WORDS = 19200,
  parameter int                LANE_IN   = 8,
  parameter int                LANE_OUT  = 32,
  parameter int                MEM_DW    = 256,
  parameter int                MEM_AW    = 28,
  parameter logic [MEM_AW-1:0] BASE_ADDR = 'h1000000,
  parameter int                ADDR_STEP = 8,
  parameter int                ROM_LAT   = 1,
  parameter int                SIGN_EXT  = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_verify,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [ROM_DW-1:0] i_rom_data,
  output logic [MEM_DW-1:0] o_mem_data_wr,
  input  logic [MEM_DW-1:0] i_mem_data_rd,
  output logic [MEM_AW-1:0] o_mem_data_addr,
  output logic              o_mem_rw_data,
  output logic              o_mem_valid_data,
  input  logic              i_mem_ready_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [ROM_AW:0]   o_err_count,
  output state_t            o_state
);

  if (MEM_DW != ROM_DW / LANE_IN * LANE_OUT) begin : g_bad_mem_dw
    $error("MEM_DW must equal ROM_DW/LANE_IN*LANE_OUT");
  end
  if (ROM_LAT < 1) begin : g_bad_rom_lat
    $error("ROM_LAT must be at least 1");
  end

  localparam int                WAIT_W    = $clog2(ROM_LAT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ROM_LAT - 1);
  // rom_addr advances in lock-step with the word index, so it doubles as idx.
  localparam logic [ROM_AW-1:0] LAST_IDX  = ROM_AW'(NUM_WORDS - 1);

  state_t              r_state;
  logic [ROM_AW-1:0]   r_rom_addr;
  logic [MEM_DW-1:0]   r_mem_data_wr;
  logic [MEM_AW-1:0]   r_mem_data_addr;
  logic                r_mem_rw;
  logic                r_mem_valid;
  logic                r_busy;
  logic                r_done;
  logic [ROM_AW:0]     r_err_count;
  logic                r_mode_verify;
  logic [WAIT_W-1:0]   r_wait;
  logic [MEM_DW-1:0]   w_expanded;

  rom_to_mem_loader_lane_expand #(
    .ROM_DW   (ROM_DW),
    .LANE_IN  (LANE_IN),
    .LANE_OUT (LANE_OUT),
    .SIGN_EXT (SIGN_EXT)
  ) u_lane_expand (
    .i_data (i_rom_data),
    .o_data (w_expanded)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= IDLE;
      r_rom_addr      <= '0;
      r_mem_data_wr   <= '0;
      r_mem_data_addr <= BASE_ADDR;
      r_mem_rw        <= MEM_WRITE;
      r_mem_valid     <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err_count     <= '0;
      r_mode_verify   <= 1'b0;
      r_wait          <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_mode_verify   <= i_verify;
            r_rom_addr      <= '0;
            r_mem_data_addr <= BASE_ADDR;
            r_mem_rw        <= i_verify ? MEM_READ : MEM_WRITE;
            r_err_count     <= '0;
            r_busy          <= 1'b1;
            r_wait          <= '0;
            r_state         <= FETCH;
          end
        end
        FETCH: begin
          // r_wait counts cycles since rom_addr last changed.
          if (r_wait == WAIT_LAST) begin
            r_mem_data_wr <= w_expanded;
            r_mem_valid   <= 1'b1;
            r_state       <= REQ;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        REQ: begin
          if (i_mem_ready_data) begin
            r_mem_valid <= 1'b0;
            if (r_mode_verify && (i_mem_data_rd != r_mem_data_wr) && (r_err_count != '1)) begin
              r_err_count <= r_err_count + (ROM_AW+1)'(1);
            end
            if (r_rom_addr == LAST_IDX) begin
              r_state <= DONE;
            end else begin
              r_rom_addr      <= r_rom_addr + ROM_AW'(1);
              r_mem_data_addr <= r_mem_data_addr + MEM_AW'(ADDR_STEP);
              r_wait          <= '0;
              r_state         <= FETCH;
            end
          end
        end
        DONE: begin
          r_done        <= 1'b1;
          r_busy        <= 1'b0;
          r_mem_data_wr <= '0;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_rom_addr       = r_rom_addr;
  assign o_mem_data_wr    = r_mem_data_wr;
  assign o_mem_data_addr  = r_mem_data_addr;
  assign o_mem_rw_data    = r_mem_rw;
  assign o_mem_valid_data = r_mem_valid;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_err_count      = r_err_count;
  assign o_state          = r_state;

endmodule

// File: tb/tb_rom_to_mem_loader.sv
// Bench for rom_to_mem_loader: dut_a (zero-extend, ROM_LAT=1) and
// dut_b (sign-extend, ROM_LAT=3), both NUM_WORDS=4. A select bit routes the
// shared stimulus/observation signals to one DUT per run.
module tb_rom_to_mem_loader;
  import rom_to_mem_loader_pkg::*;

  localparam int          N    = 4;
  localparam logic [27:0] BASE = 28'h1000000;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // shared stimulus
  logic         sel = 1'b0;
  logic         start = 1'b0;
  logic         verify = 1'b0;
  logic         ready = 1'b0;
  logic [255:0] mem_rd = '0;

  // dut_a signals
  logic [15:0]  rom_addr_a;   logic [63:0] rom_data_a;
  logic [255:0] wr_a;         logic [27:0] addr_a;
  logic         rw_a, valid_a, busy_a, done_a;
  logic [16:0]  err_a;        state_t      state_a;
  // dut_b signals
  logic [15:0]  rom_addr_b;   logic [63:0] rom_data_b;
  logic [255:0] wr_b;         logic [27:0] addr_b;
  logic         rw_b, valid_b, busy_b, done_b;
  logic [16:0]  err_b;        state_t      state_b;
  logic [63:0]  rom_p1 = '0, rom_p2 = '0;

  function automatic logic [63:0] rom_word(input bit s, input int i);
    if (s) return 64'h7F807F807F807F00 | 64'(i & 255);
    return 64'h0807060504030201 + 64'(i);
  endfunction

  function automatic logic [255:0] expand(input logic [63:0] w, input bit sext);
    logic [255:0] r;
    logic [7:0]   b;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      b = w[8*k +: 8];
      r[32*k +: 32] = {(sext && b[7]) ? 24'hFFFFFF : 24'h000000, b};
    end
    return r;
  endfunction

  // ROM models: A answers combinationally (latency 1), B through two more stages (latency 3)
  assign rom_data_a = rom_word(1'b0, int'(rom_addr_a));
  always @(posedge clk) begin
    rom_p1 <= rom_word(1'b1, int'(rom_addr_b));
    rom_p2 <= rom_p1;
  end
  assign rom_data_b = rom_p2;

  rom_to_mem_loader #(.NUM_WORDS(N), .ROM_LAT(1), .SIGN_EXT(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start & ~sel), .i_verify(verify),
    .o_rom_addr(rom_addr_a), .i_rom_data(rom_data_a),
    .o_mem_data_wr(wr_a), .i_mem_data_rd(mem_rd), .o_mem_data_addr(addr_a),
    .o_mem_rw_data(rw_a), .o_mem_valid_data(valid_a), .i_mem_ready_data(ready & ~sel),
    .o_busy(busy_a), .o_done(done_a), .o_err_count(err_a), .o_state(state_a)
  );

  rom_to_mem_loader #(.NUM_WORDS(N), .ROM_LAT(3), .SIGN_EXT(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start & sel), .i_verify(verify),
    .o_rom_addr(rom_addr_b), .i_rom_data(rom_data_b),
    .o_mem_data_wr(wr_b), .i_mem_data_rd(mem_rd), .o_mem_data_addr(addr_b),
    .o_mem_rw_data(rw_b), .o_mem_valid_data(valid_b), .i_mem_ready_data(ready & sel),
    .o_busy(busy_b), .o_done(done_b), .o_err_count(err_b), .o_state(state_b)
  );

  logic [15:0]  m_rom_addr; logic [255:0] m_wr; logic [27:0] m_addr;
  logic         m_rw, m_valid, m_busy, m_done;
  logic [16:0]  m_err;      state_t m_state;
  assign m_rom_addr = sel ? rom_addr_b : rom_addr_a;
  assign m_wr       = sel ? wr_b    : wr_a;
  assign m_addr     = sel ? addr_b  : addr_a;
  assign m_rw       = sel ? rw_b    : rw_a;
  assign m_valid    = sel ? valid_b : valid_a;
  assign m_busy     = sel ? busy_b  : busy_a;
  assign m_done     = sel ? done_b  : done_a;
  assign m_err      = sel ? err_b   : err_a;
  assign m_state    = sel ? state_b : state_a;

  // scoreboard
  int           n_checks = 0;
  int           n_err = 0;
  logic [255:0] exp_q[$];
  logic [27:0]  exp_addr_q[$];
  logic [255:0] first_data;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rom_addr"}, m_rom_addr, 0);
    check({tag, "_wr"},       m_wr, 0);
    check({tag, "_addr"},     m_addr, BASE);
    check({tag, "_rw"},       m_rw, 1);
    check({tag, "_valid"},    m_valid, 0);
    check({tag, "_busy"},     m_busy, 0);
    check({tag, "_done"},     m_done, 0);
    check({tag, "_err"},      m_err, 0);
    check({tag, "_state"},    m_state, IDLE);
  endtask

  // One run: s selects the DUT, dly = ready delay per request, bad_word gets a
  // corrupted read-back lane 0, rst_word aborts the run by reset at that word,
  // poke pulses start (and a stray ready) while the run is busy.
  task automatic run(input bit s, input bit ver, input int dly, input int bad_word,
                     input int rst_word, input bit poke);
    int          lat, waits, dones, t_v;
    logic [255:0] ed;
    logic [27:0]  ea;
    lat = s ? 3 : 1;
    sel = s;
    t_v = 0;
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_addr_q.push_back(BASE + 28'(8 * i));
      exp_q.push_back(expand(rom_word(s, i), s));
    end
    verify = ver;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    verify = ~ver;
    for (int w = 0; w < N; w++) begin
      waits = 0;
      while (!m_valid && waits < 40) begin
        start = (poke && w == 1 && waits == 0);
        ready = poke;
        @(negedge clk);
        waits++;
      end
      start = 1'b0;
      ready = 1'b0;
      if (!m_valid) begin
        check("valid_timeout", m_valid, 1);
        return;
      end
      if (w == 0) t_v = cyc;
      ea = exp_addr_q.pop_front();
      ed = exp_q.pop_front();
      check("fetch_cycles", waits, lat);
      check("addr", m_addr, ea);
      check("data", m_wr, ed);
      check("rw", m_rw, ver ? 0 : 1);
      check("busy", m_busy, 1);
      if (w == 0) first_data = m_wr;
      if (w == rst_word) begin
        #2 rst = 1'b1;
        #1 check_reset("rst_async");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      for (int d = 0; d < dly; d++) begin
        @(negedge clk);
        check("hold_valid", m_valid, 1);
        check("hold_addr", m_addr, ea);
        check("hold_data", m_wr, ed);
        check("hold_rw", m_rw, ver ? 0 : 1);
      end
      mem_rd = (w == bad_word) ? (ed ^ 256'h1) : ed;
      ready  = 1'b1;
      @(negedge clk);
      ready  = 1'b0;
      check("valid_drop", m_valid, 0);
    end
    waits = 0;
    while (!m_done && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    check("done_wait", waits, 1);
    check("done", m_done, 1);
    check("done_time", cyc - t_v, (N - 1) * (lat + 1 + dly) + dly + 2);
    check("done_busy", m_busy, 0);
    check("done_wr", m_wr, 0);
    check("err_count", m_err, (ver && bad_word >= 0 && bad_word < N) ? 1 : 0);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_done) dones++;
      if (m_valid) dones += 100;
    end
    check("after_done_quiet", dones, 0);
    check("after_state", m_state, IDLE);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("rst_init");
    rst = 1'b0;
    @(negedge clk);

    run(1'b0, 1'b0, 0, -1, -1, 1'b0);
    check("word0_data", first_data,
          256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
    run(1'b0, 1'b0, 5, -1, -1, 1'b0);
    run(1'b0, 1'b1, 0, 2, -1, 1'b0);
    run(1'b0, 1'b1, 1, 0, 2, 1'b0);
    run(1'b0, 1'b0, 0, -1, -1, 1'b0);
    run(1'b1, 1'b0, 0, -1, -1, 1'b1);
    check("sext_lane2", first_data[95:64], 32'hFFFFFF80);
    check("sext_lane1", first_data[63:32], 32'h0000007F);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
